finger_scan_controller: RTL and testbench
=========================================

Name: finger_scan_controller

Overview:
Sequences one shared flex-sensor ADC across the five finger channels: thumb=0, index=1, middle=2, ring=3, pinky=4. Each sample is thresholded into a bent/straight bit. A 5-bit vector is accepted only after it is stable over several full scans. The accepted per-finger status bits drive the sign identification stage, with a one-cycle update strobe.

Parameters:
ADC_W, 10, ADC sample width in bits
THRESH, 512, sample >= THRESH means finger bent (status=1)
SCAN_GAP, 1000, idle clk cycles between scans (>=1)
STABLE_SCANS, 3, identical consecutive raw vectors required before outputs update (>=1)
ADC_TIMEOUT, 255, max clk cycles waiting for adc_done
HYST, 32, hysteresis half-band (used only with HYSTERESIS_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
enable  in  1  1 = scanning allowed; sampled only in IDLE
adc_start  out  1  one-cycle conversion request
adc_ch  out  3  channel select, valid and held from START through end of WAIT
adc_done  in  1  one-cycle pulse, conversion finished
adc_data  in  ADC_W  sample, valid when adc_done=1
thumb_status  out  1  debounced finger status
index_status  out  1  debounced finger status
middle_status  out  1  debounced finger status
ring_status  out  1  debounced finger status
pinky_status  out  1  debounced finger status
status_update  out  1  one-cycle pulse when any status output changes
adc_error  out  1  sticky; set on timeout

Behaviour:
- Reset (rst=0, async): FSM=IDLE, gap counter=0, channel=0, raw vector=0, previous raw vector=0, stable count=0. All outputs 0.
- FSM states:
  - IDLE: gap counter counts to SCAN_GAP-1. When it reaches SCAN_GAP-1 and enable=1, go to START with channel=0. If enable=0, hold the counter at SCAN_GAP-1.
  - START: adc_start=1 for exactly one cycle with adc_ch=channel; go to WAIT and clear the timeout counter.
  - WAIT: on adc_done, latch the compare bit into raw[channel].
    - channel<4: channel+1, go to START.
    - channel==4: go to EVAL.
    - Timeout counter reaching ADC_TIMEOUT: set adc_error, discard the partial scan, go to IDLE. Stable count and outputs are unchanged.
  - EVAL (one cycle):
    - raw==prev: stable count increments, saturating at STABLE_SCANS. Otherwise stable count=1 and prev=raw.
    - Stable count (after update) ==STABLE_SCANS and raw differs from current outputs: outputs<=raw, status_update=1 next cycle.
    - Go to IDLE with gap counter=0.
- Compare is unsigned: bit = (adc_data >= THRESH).
- adc_done outside WAIT is ignored. adc_done in the same cycle as the timeout: the sample wins and no error is set.
- Scan latency: 5 conversions + 6 FSM cycles + conversion time. Minimum time to a status change after a stable input flip is STABLE_SCANS scans.
- adc_error clears only on reset.
- status_update and adc_start never exceed one cycle.

Optional Feature:
HYSTERESIS_EN:
- Defined: the set/clear threshold depends on the current debounced status of that finger.
  - Status=0: bit=1 when adc_data >= THRESH+HYST.
  - Status=1: bit=0 when adc_data < THRESH-HYST; otherwise bit=1.
  - Threshold arithmetic uses ADC_W+1 bits and saturates at 0 and 2^ADC_W-1.
- Undefined: single threshold THRESH; the HYST parameter is unused.

Decomposition:
- Shared package gesture_pkg:
  - FSM state enum (IDLE, START, WAIT, EVAL).
  - Finger index constants FINGER_THUMB..FINGER_PINKY (0..4).
  - NUM_FINGERS=5.
  - Channel width constant 3.
- One natural sub-module: finger_threshold. It is combinational compare with optional hysteresis, instanced once on the muxed channel.

Test Plan:
- rst=0 mid-WAIT with adc_start just issued -> all outputs 0 immediately. After release, the first adc_start occurs SCAN_GAP+1 cycles later.
- enable=1, ADC model returns 600 on ch1,ch3 and 100 elsewhere, done 4 cycles after start, STABLE_SCANS=3 -> channels issued 0..4 in order. After the 3rd scan's EVAL: index_status=1, ring_status=1, others 0, with exactly one status_update pulse.
- Ch2 toggles 600/100 every scan -> middle_status never changes and there is no status_update.
- Model withholds adc_done on ch2 -> adc_error=1 after 255 wait cycles. Outputs unchanged; the next scan starts at ch0 after SCAN_GAP.
- HYSTERESIS_EN defined, THRESH=512, HYST=32, ch0 stable at 530 -> thumb stays 0. Stable at 550 -> thumb=1. Then stable at 500 -> thumb stays 1. Then 470 -> thumb=0.
- enable=0 in IDLE -> no adc_start for 5000 cycles. Setting enable=1 -> adc_start on the next cycle (counter held at SCAN_GAP-1).

Source files
------------

// File: rtl/gesture_pkg.sv
// +------------------------------------------------------------------------+
// | Module  : gesture_pkg                                                  |
// | Purpose : Shared types and constants for the finger scan controller:   |
// |           scan FSM state encoding, finger channel numbers, channel     |
// |           select width and finger count.                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
`default_nettype none

package gesture_pkg;

    localparam int NUM_FINGERS = 5;
    localparam int CH_W        = 3;

    localparam logic [CH_W-1:0] FINGER_THUMB  = 3'd0;
    localparam logic [CH_W-1:0] FINGER_INDEX  = 3'd1;
    localparam logic [CH_W-1:0] FINGER_MIDDLE = 3'd2;
    localparam logic [CH_W-1:0] FINGER_RING   = 3'd3;
    localparam logic [CH_W-1:0] FINGER_PINKY  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        EVAL  = 2'd3
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/finger_scan_controller_if.sv
// +------------------------------------------------------------------------+
// | Module  : finger_scan_controller_if                                    |
// | Purpose : Conversion handshake between the scan controller and the     |
// |           shared flex-sensor ADC.                                      |
// |   adc_start : one-cycle conversion request (controller -> ADC)         |
// |   adc_ch    : channel select, held from START through end of WAIT      |
// |   adc_done  : one-cycle pulse, conversion finished (ADC -> controller) |
// |   adc_data  : sample, valid while adc_done=1                           |
// |   master modport = controller side, slave modport = ADC side           |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
`default_nettype none

interface finger_scan_controller_if
    import gesture_pkg::*;
#(
    parameter int ADC_W = 10
) ();

    logic              adc_start;
    logic [CH_W-1:0]   adc_ch;
    logic              adc_done;
    logic [ADC_W-1:0]  adc_data;

    modport master (
        output adc_start,
        output adc_ch,
        input  adc_done,
        input  adc_data
    );

    modport slave (
        input  adc_start,
        input  adc_ch,
        output adc_done,
        output adc_data
    );

endinterface

`default_nettype wire

// File: rtl/finger_scan_controller_threshold.sv
// +------------------------------------------------------------------------+
// | Module  : finger_threshold                                             |
// | Purpose : Combinational bent/straight decision for one ADC sample.     |
// |   i_sample : ADC sample (unsigned)                                     |
// |   i_status : current debounced status of the finger being sampled      |
// |   o_bent   : 1 = finger bent                                           |
// | Build option HYSTERESIS_EN: set threshold THRESH+HYST while straight,  |
// |   clear threshold THRESH-HYST while bent, both saturated to the ADC    |
// |   range. Without it a single threshold THRESH is used.                 |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
`default_nettype none

module finger_threshold
    import gesture_pkg::*;
#(
    parameter int ADC_W  = 10,
    parameter int THRESH = 512,
    parameter int HYST   = 32
) (
    input  wire logic [ADC_W-1:0] i_sample,
    input  wire logic             i_status,
    output logic                  o_bent
);

    localparam int C_MAX = (1 << ADC_W) - 1;

    // One extra bit so every threshold (including "never bent") is representable.
    logic [ADC_W:0] w_sample_ext;
    assign w_sample_ext = {1'b0, i_sample};

`ifdef HYSTERESIS_EN
    localparam int C_HI_INT = (THRESH + HYST > C_MAX) ? C_MAX : (THRESH + HYST);
    localparam int C_LO_INT = (THRESH - HYST < 0) ? 0 : (THRESH - HYST);
    localparam logic [ADC_W:0] C_HI = C_HI_INT[ADC_W:0];
    localparam logic [ADC_W:0] C_LO = C_LO_INT[ADC_W:0];

    // A bent finger stays bent until the sample drops below the low threshold.
    assign o_bent = i_status ? (w_sample_ext >= C_LO) : (w_sample_ext >= C_HI);
`else
    localparam int C_TH_INT = (THRESH > C_MAX + 1) ? (C_MAX + 1) : THRESH;
    localparam logic [ADC_W:0] C_TH = C_TH_INT[ADC_W:0];

    assign o_bent = (w_sample_ext >= C_TH);

    // Status and half-band only matter in the hysteresis build.
    logic w_unused_hyst;
    assign w_unused_hyst = ^{i_status, HYST[0]};
`endif

endmodule

`default_nettype wire

// File: rtl/finger_scan_controller.sv
// +------------------------------------------------------------------------+
// | Module  : finger_scan_controller                                       |
// | Purpose : Sequences one shared ADC over the five finger channels       |
// |           (thumb=0 .. pinky=4), thresholds each sample, and only       |
// |           accepts a new 5-bit status vector once it has been seen in   |
// |           STABLE_SCANS consecutive identical scans.                    |
// | Ports   :                                                              |
// |   clk            system clock                                          |
// |   rst            asynchronous, active-low reset                        |
// |   enable         scanning allowed; only looked at while idle           |
// |   adc            conversion handshake (master modport)                 |
// |   *_status       debounced finger status (1 = bent)                    |
// |   status_update  one-cycle pulse when the status vector changes        |
// |   adc_error      sticky conversion-timeout flag, cleared by reset      |
// | Build option HYSTERESIS_EN: see finger_threshold.                      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
`default_nettype none

module finger_scan_controller
    import gesture_pkg::*;
#(
    parameter int ADC_W        = 10,
    parameter int THRESH       = 512,
    parameter int SCAN_GAP     = 1000,
    parameter int STABLE_SCANS = 3,
    parameter int ADC_TIMEOUT  = 255,
    parameter int HYST         = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 enable,
    finger_scan_controller_if.master  adc,
    output logic                      thumb_status,
    output logic                      index_status,
    output logic                      middle_status,
    output logic                      ring_status,
    output logic                      pinky_status,
    output logic                      status_update,
    output logic                      adc_error
);

    localparam int C_GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam int C_TMO_W = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
    localparam int C_CNT_W = $clog2(STABLE_SCANS + 1);

    localparam logic [C_GAP_W-1:0] C_GAP_LAST = C_GAP_W'(SCAN_GAP - 1);
    // WAIT cycle index at which the timeout fires (ADC_TIMEOUT-th wait cycle).
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(ADC_TIMEOUT - 1);
    localparam logic [C_CNT_W-1:0] C_STABLE   = C_CNT_W'(STABLE_SCANS);

    scan_state_t              r_state;
    logic [C_GAP_W-1:0]       r_gap;
    logic [C_TMO_W-1:0]       r_tmo;
    logic [CH_W-1:0]          r_ch;
    logic [NUM_FINGERS-1:0]   r_raw;
    logic [NUM_FINGERS-1:0]   r_prev;
    logic [NUM_FINGERS-1:0]   r_status;
    logic [C_CNT_W-1:0]       r_cnt;
    logic                     r_start;
    logic                     r_update;
    logic                     r_error;

    logic                     w_cur;
    logic                     w_bent;
    logic                     w_same;
    logic [C_CNT_W-1:0]       w_cnt_next;

    // Debounced status of the finger currently being converted (for hysteresis).
    always_comb begin
        w_cur = 1'b0;
        for (int i = 0; i < NUM_FINGERS; i++) begin
            if (r_ch == CH_W'(i)) begin
                w_cur = r_status[i];
            end
        end
    end

    finger_threshold #(
        .ADC_W  (ADC_W),
        .THRESH (THRESH),
        .HYST   (HYST)
    ) u_threshold (
        .i_sample (adc.adc_data),
        .i_status (w_cur),
        .o_bent   (w_bent)
    );

    assign w_same = (r_raw == r_prev);

    always_comb begin
        w_cnt_next = C_CNT_W'(1);
        if (w_same) begin
            w_cnt_next = (r_cnt == C_STABLE) ? r_cnt : (r_cnt + C_CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_gap    <= '0;
            r_tmo    <= '0;
            r_ch     <= FINGER_THUMB;
            r_raw    <= '0;
            r_prev   <= '0;
            r_status <= '0;
            r_cnt    <= '0;
            r_start  <= 1'b0;
            r_update <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            // Both strobes are single-cycle unless re-armed below.
            r_start  <= 1'b0;
            r_update <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_gap == C_GAP_LAST) begin
                        // Counter parks here while disabled so enable starts a scan at once.
                        if (enable) begin
                            r_state <= START;
                            r_ch    <= FINGER_THUMB;
                            r_start <= 1'b1;
                        end
                    end else begin
                        r_gap <= r_gap + C_GAP_W'(1);
                    end
                end

                START: begin
                    r_tmo   <= '0;
                    r_state <= WAIT;
                end

                WAIT: begin
                    // A sample arriving on the timeout cycle takes priority.
                    if (adc.adc_done) begin
                        for (int i = 0; i < NUM_FINGERS; i++) begin
                            if (r_ch == CH_W'(i)) begin
                                r_raw[i] <= w_bent;
                            end
                        end
                        if (r_ch == FINGER_PINKY) begin
                            r_state <= EVAL;
                        end else begin
                            r_ch    <= r_ch + CH_W'(1);
                            r_state <= START;
                            r_start <= 1'b1;
                        end
                    end else if (r_tmo == C_TMO_LAST) begin
                        // Partial scan is abandoned; debounce state is left untouched.
                        r_error <= 1'b1;
                        r_state <= IDLE;
                        r_gap   <= '0;
                        r_ch    <= FINGER_THUMB;
                    end else begin
                        r_tmo <= r_tmo + C_TMO_W'(1);
                    end
                end

                EVAL: begin
                    r_cnt <= w_cnt_next;
                    if (!w_same) begin
                        r_prev <= r_raw;
                    end
                    if ((w_cnt_next == C_STABLE) && (r_raw != r_status)) begin
                        r_status <= r_raw;
                        r_update <= 1'b1;
                    end
                    r_state <= IDLE;
                    r_gap   <= '0;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign adc.adc_start  = r_start;
    assign adc.adc_ch     = r_ch;

    assign thumb_status   = r_status[FINGER_THUMB];
    assign index_status   = r_status[FINGER_INDEX];
    assign middle_status  = r_status[FINGER_MIDDLE];
    assign ring_status    = r_status[FINGER_RING];
    assign pinky_status   = r_status[FINGER_PINKY];
    assign status_update  = r_update;
    assign adc_error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_finger_scan_controller.sv
// +------------------------------------------------------------------------+
// | Module  : tb_finger_scan_controller                                    |
// | Purpose : Self-checking bench for finger_scan_controller. A behavioural|
// |           ADC answers each request 4 cycles later; expected status     |
// |           vectors are queued by the stimulus and checked by a monitor  |
// |           whenever status_update pulses.                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_finger_scan_controller;
    import gesture_pkg::*;

    localparam int ADC_W        = 10;
    localparam int THRESH       = 512;
    localparam int SCAN_GAP     = 40;
    localparam int STABLE_SCANS = 3;
    localparam int ADC_TIMEOUT  = 255;
    localparam int HYST         = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic thumb_status, index_status, middle_status, ring_status, pinky_status;
    logic status_update, adc_error;
    logic [4:0] st;

    finger_scan_controller_if #(.ADC_W(ADC_W)) adc ();

    finger_scan_controller #(
        .ADC_W        (ADC_W),
        .THRESH       (THRESH),
        .SCAN_GAP     (SCAN_GAP),
        .STABLE_SCANS (STABLE_SCANS),
        .ADC_TIMEOUT  (ADC_TIMEOUT),
        .HYST         (HYST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .adc           (adc),
        .thumb_status  (thumb_status),
        .index_status  (index_status),
        .middle_status (middle_status),
        .ring_status   (ring_status),
        .pinky_status  (pinky_status),
        .status_update (status_update),
        .adc_error     (adc_error)
    );

    always #5 clk = ~clk;

    assign st = {pinky_status, ring_status, middle_status, index_status, thumb_status};

    int         errors = 0;
    int         checks = 0;
    int         updates = 0;
    logic [4:0] exp_q[$];
    int         vals[5];
    int         hold_ch = -1;
    bit         tog_ch2 = 1'b0;
    bit         tog_state = 1'b0;
    logic       prev_start = 1'b0;
    logic       prev_upd = 1'b0;
    logic       prev_err = 1'b0;
    int         exp_ch = 0;

`ifdef HYSTERESIS_EN
    // Index channel sits at exactly 512, below the 544 set threshold.
    localparam logic [4:0] C_VEC_C = 5'b10001;
    localparam logic [4:0] C_BASE  = 5'b10000;
    localparam bit C_THUMB_EXP [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    localparam logic [4:0] C_VEC_C = 5'b10011;
    localparam logic [4:0] C_BASE  = 5'b10010;
    localparam bit C_THUMB_EXP [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    localparam int C_THUMB_VAL [5] = '{100, 530, 550, 500, 470};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural ADC: done pulses on the 4th cycle after the request.
    initial begin
        adc.adc_done = 1'b0;
        adc.adc_data = '0;
        forever begin
            @(negedge clk);
            adc.adc_done = 1'b0;
            if (adc.adc_start && rst) begin
                int ch;
                ch = int'(adc.adc_ch);
                repeat (3) @(negedge clk);
                if (ch != hold_ch) begin
                    adc.adc_done = 1'b1;
                    if (ch == 2 && tog_ch2) begin
                        adc.adc_data = tog_state ? 10'd600 : 10'd100;
                        tog_state = ~tog_state;
                    end else begin
                        adc.adc_data = ADC_W'(vals[ch]);
                    end
                end
            end
        end
    end

    // Monitor: strobe widths, channel order, and status vectors from the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst || (adc_error && !prev_err)) exp_ch = 0;
            if (adc.adc_start) begin
                check("adc_start_width", int'(prev_start), 0);
                check("adc_ch_order", int'(adc.adc_ch), exp_ch);
                exp_ch = (exp_ch == 4) ? 0 : exp_ch + 1;
            end
            if (status_update) begin
                updates++;
                check("status_update_width", int'(prev_upd), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update: got %b expected no update", st);
                end else begin
                    check("status_vector", int'(st), int'(exp_q.pop_front()));
                end
            end
            prev_start = adc.adc_start;
            prev_upd   = status_update;
            prev_err   = adc_error;
        end
    end

    task automatic wait_scans(input int k, input string name);
        int seen = 0;
        int cyc = 0;
        while (seen < k && cyc < k * 2000) begin
            @(negedge clk);
            cyc++;
            if (adc.adc_start && adc.adc_ch == 3'd0) seen++;
        end
        if (seen < k) begin
            checks++;
            errors++;
            $display("FAIL %s: saw %0d scan starts required %0d", name, seen, k);
        end
    endtask

    task automatic measure_start(output int n);
        n = 0;
        while (!adc.adc_start && n < 10 * SCAN_GAP) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int cyc;
        int starts;
        bit prev_thumb;
        vals = '{100, 600, 100, 600, 100};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_adc_start", int'(adc.adc_start), 0);
        check("reset_adc_ch", int'(adc.adc_ch), 0);
        check("reset_status", int'(st), 0);
        check("reset_update", int'(status_update), 0);
        check("reset_error", int'(adc_error), 0);

        // Index and ring bent: accepted after the third identical scan
        enable = 1'b1;
        rst = 1'b1;
        measure_start(n);
        // Register-output start: SCAN_GAP or SCAN_GAP+1 depending on edge counting.
        checks++;
        if (n < SCAN_GAP || n > SCAN_GAP + 1) begin
            errors++;
            $display("FAIL first_start_latency: got %0d expected %0d..%0d", n, SCAN_GAP, SCAN_GAP + 1);
        end
        exp_q.push_back(5'b01010);
        wait_scans(2, "scan_a1");
        check("no_update_before_3rd", updates, 0);
        check("status_before_3rd", int'(st), 0);
        wait_scans(1, "scan_a2");
        check("updates_after_3rd", updates, 1);
        check("status_after_3rd", int'(st), 5'b01010);
        wait_scans(2, "scan_a3");
        check("no_repeat_update", updates, 1);

        // Middle toggles every scan: never stable
        tog_ch2 = 1'b1;
        tog_state = 1'b1;
        wait_scans(6, "scan_b");
        check("toggle_no_update", updates, 1);
        check("toggle_middle", int'(middle_status), 0);
        tog_ch2 = 1'b0;

        // Asynchronous reset right after a request clears everything at once
        rst = 1'b0;
        #1;
        check("midreset_adc_start", int'(adc.adc_start), 0);
        check("midreset_status", int'(st), 0);
        check("midreset_update", int'(status_update), 0);
        vals = '{1023, 512, 511, 0, 600};
        repeat (3) @(negedge clk);
        rst = 1'b1;
        measure_start(n);
        checks++;
        if (n < SCAN_GAP || n > SCAN_GAP + 1) begin
            errors++;
            $display("FAIL restart_latency: got %0d expected %0d..%0d", n, SCAN_GAP, SCAN_GAP + 1);
        end
        exp_q.push_back(C_VEC_C);
        wait_scans(4, "scan_c");
        check("boundary_status", int'(st), int'(C_VEC_C));
        check("boundary_updates", updates, 2);

        // Middle conversion never completes: timeout after 255 wait cycles
        hold_ch = 2;
        cyc = 0;
        while (!(adc.adc_start && adc.adc_ch == 3'd2) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        n = 0;
        while (!adc_error && n < 1000) begin
            @(negedge clk);
            n++;
        end
        // One START cycle plus 255 WAIT cycles.
        check("timeout_cycles", n, ADC_TIMEOUT + 1);
        check("timeout_status_kept", int'(st), int'(C_VEC_C));
        measure_start(n);
        check("post_error_gap", n, SCAN_GAP);
        check("post_error_ch", int'(adc.adc_ch), 0);
        hold_ch = -1;
        check("error_after_recovery", int'(adc_error), 1);

        // enable low: finish this scan, then no requests while disabled
        enable = 1'b0;
        cyc = 0;
        while (!(adc.adc_start && adc.adc_ch == 3'd4) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        starts = 0;
        repeat (5000) begin
            @(negedge clk);
            if (adc.adc_start) starts++;
        end
        check("disabled_no_start", starts, 0);
        enable = 1'b1;
        @(negedge clk);
        check("enable_immediate_start", int'(adc.adc_start), 1);
        check("enable_start_ch", int'(adc.adc_ch), 0);
        check("error_sticky", int'(adc_error), 1);

        // Thumb threshold sequence (hysteresis-dependent expectations)
        prev_thumb = 1'b1;
        n = updates;
        for (int s = 0; s < 5; s++) begin
            vals[0] = C_THUMB_VAL[s];
            if (C_THUMB_EXP[s] != prev_thumb) begin
                exp_q.push_back(C_BASE | {4'b0, C_THUMB_EXP[s]});
                n++;
            end
            prev_thumb = C_THUMB_EXP[s];
            wait_scans(4, "scan_thumb");
            check("thumb_status", int'(thumb_status), int'(C_THUMB_EXP[s]));
            check("thumb_updates", updates, n);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
